instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Upstream neighbour of the main control decoder: owns the PC, fetches 32-bit LEGv8 words from instruction memory
//  over a valid/ready handshake, and holds each word in an instruction register until decode accepts it.
//  Drives opcode = instr[31:21] straight into the control decoder; accepts CBZ redirects (Branch & Zero) from execute.
// PARAMETERS
//  PC_W      64             program-counter / address width (bits)
//  RESET_PC  {PC_W{1'b0}}   PC value loaded on reset; bits [1:0] must be 0
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous active-low reset
//  imem_req       out  1      fetch request; held high, address stable, until imem_ready
//  imem_addr      out  PC_W   word-aligned fetch address
//  imem_ready     in   1      one-cycle pulse: imem_rdata valid this cycle
//  imem_rdata     in   32     fetched instruction word
//  instr_valid    out  1      instr/opcode/instr_pc hold a valid instruction
//  instr_ready    in   1      decode accepts instruction when instr_valid & instr_ready
//  instr          out  32     held instruction word
//  opcode         out  11     instr[31:21], to control decoder
//  instr_pc       out  PC_W   address the held instruction was fetched from
//  redirect       in   1      branch taken; sampled every cycle
//  redirect_pc    in   PC_W   branch target; bits [1:0] ignored (forced 0)
//  misalign_err   out  1      sticky: a redirect_pc with nonzero [1:0] was seen; cleared only by reset
// BEHAVIOUR
//  Reset (async assert, sync-to-clk deassert by system): state=REQ, pc=RESET_PC, imem_req=0, instr_valid=0,
//   instr=32'h0, opcode=11'h0, instr_pc=0, misalign_err=0, drop=0. First imem_req rises the cycle after rst_n high.
//  States:
//   REQ:  imem_req=1, imem_addr=pc. On imem_ready: if drop|redirect -> discard rdata, clear drop, stay REQ
//         (pc=redirect target if redirect this cycle). Else capture rdata->instr, pc->instr_pc, go HOLD.
//   HOLD: instr_valid=1, imem_req=0. On instr_valid&instr_ready: pc<=pc+4, go REQ. Outputs stable otherwise.
//  Redirect handling (priority over every other event in the same cycle):
//   - pc <= {redirect_pc[PC_W-1:2],2'b00}; state <= REQ; instr_valid drops next cycle.
//   - In REQ with request outstanding and no imem_ready this cycle: imem_req stays high on OLD address until
//     imem_ready (no abort); drop<=1; returning word is discarded; then new request at target.
//   - In HOLD: held instruction is flushed even if instr_ready is high the same cycle (handshake ignored).
//  Latency: imem_ready at cycle N -> instr_valid at N+1; accept at M -> imem_req for pc+4 at M+1.
//   Zero-wait memory => 1 instruction per 2 cycles.
//  Arithmetic: pc+4 modulo 2^PC_W (wraps to 0 silently). Only one fetch outstanding, ever.
//  imem_req must never deassert while a request is outstanding; imem_addr must not change while imem_req=1.
//  Reset asserted mid-fetch: all state cleared immediately; any late imem_ready after reset is ignored
//   until the first post-reset request is issued.
// STRUCTURE
//  Shared include arm_defs.vh: INSTR_W=32, OPCODE_MSB=31, OPCODE_LSB=21, PC_INC=4, fetch state encodings
//   (FS_REQ, FS_HOLD), default RESET_PC.
//  One sub-module: if_pc_reg (PC register: reset load, +4 increment, redirect load with [1:0] masking).
//  FSM, drop flag and instruction register live in instr_fetch_unit.
// TESTING
//  1 Reset, zero-wait mem, instr_ready=1: imem_addr 0,4,8,...; instr_valid every 2nd cycle; opcode==rdata[31:21].
//  2 Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr, instr_pc stable, imem_req=0; release -> addr+4.
//  3 Redirect to 0x100 while a fetch of 0x8 is outstanding (3-cycle mem) -> word for 0x8 dropped,
//    next imem_addr=0x100, instr_pc=0x100.
//  4 Redirect 0x40 in HOLD with instr_ready=1 same cycle -> no accept counted, next fetch 0x40.
//  5 PC_W=8, RESET_PC=8'hFC -> after one accept imem_addr=8'h00; redirect_pc=8'h13 -> addr 8'h10, misalign_err=1.
//  6 Assert rst_n low mid-fetch with imem_ready pulse during reset -> all outputs at reset values, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - instruction word / opcode field geometry
//   - PC increment per fetched word
//   - fetch FSM state type and encodings
//   - helper to extract the control-decoder opcode from a word
package instr_fetch_unit_pkg;

    localparam int INSTR_W    = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 21;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int PC_INC     = 4;

    // Two-state fetch FSM, kept as plain constants for legacy tooling.
    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t FS_REQ  = 1'b0;
    localparam fetch_state_t FS_HOLD = 1'b1;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus.
//   imem_req    fetch request, held with a stable address until imem_ready
//   imem_addr   word-aligned fetch address
//   imem_ready  one-cycle pulse: imem_rdata is valid this cycle
//   imem_rdata  fetched instruction word
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int PC_W = 64
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// if_pc_reg: program-counter register for the fetch unit.
//   clk, rst_n  clock / asynchronous active-low reset (loads RESET_PC)
//   inc         advance pc by one instruction word (wraps modulo 2^PC_W)
//   load        load load_pc with bits [1:0] forced to zero; wins over inc
//   load_pc     redirect target
//   pc          current program counter
module if_pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_pc,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc & ~PC_W'(3);
        end else if (inc) begin
            pc_d = pc_q + PC_W'(PC_INC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches one instruction word at a time from
// instruction memory and holds it until decode takes it.
//   clk, rst_n    clock / asynchronous active-low reset
//   imem          fetch bus (master side)
//   instr_valid   instr/opcode/instr_pc hold a valid instruction
//   instr_ready   decode accepts when instr_valid & instr_ready
//   instr         held instruction word
//   opcode        instr[31:21] for the control decoder
//   instr_pc      address the held instruction came from
//   redirect      taken branch, sampled every cycle, beats every other event
//   redirect_pc   branch target, bits [1:0] ignored
//   misalign_err  sticky: a redirect target had nonzero [1:0]
//   dbg_state     current fetch FSM state
//
// Handshakes: a transfer happens on a rising edge where the producer's valid
// (imem_req / instr_valid) and the consumer's ready (imem_ready / instr_ready)
// are both high; the producer holds valid and payload stable until then.
// Exception: a redirect flushes the held instruction even if instr_ready is high.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_unit_if.master   imem,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [INSTR_W-1:0]   instr,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [PC_W-1:0]      instr_pc,
    input  logic                 redirect,
    input  logic [PC_W-1:0]      redirect_pc,
    output logic                 misalign_err,
    output fetch_state_t         dbg_state
);

    fetch_state_t       state_d, state_q;
    logic               started_d, started_q;
    logic               drop_d, drop_q;
    logic [PC_W-1:0]    addr_hold_d, addr_hold_q;
    logic [INSTR_W-1:0] instr_d, instr_q;
    logic [PC_W-1:0]    instr_pc_d, instr_pc_q;
    logic               misalign_d, misalign_q;

    logic [PC_W-1:0]    pc;
    logic               pc_inc;
    logic               imem_req_w;
    logic               fire;

    if_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (pc_inc),
        .load    (redirect),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    // started_q keeps imem_req low while in reset and for the first cycle
    // after release, so a stray imem_ready around reset is never taken.
    assign imem_req_w = (state_q == FS_REQ) && started_q;
    assign fire       = imem_req_w && imem.imem_ready;

    always_comb begin
        state_d     = state_q;
        started_d   = 1'b1;
        drop_d      = drop_q;
        addr_hold_d = addr_hold_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        misalign_d  = misalign_q | (redirect & (|redirect_pc[1:0]));
        pc_inc      = 1'b0;

        if (redirect) begin
            state_d = FS_REQ;
            if (imem_req_w) begin
                if (fire) begin
                    // Word returning now belongs to the old path: discard it.
                    drop_d = 1'b0;
                end else begin
                    // Request in flight cannot be aborted: keep presenting the
                    // old address until it completes, then throw the word away.
                    drop_d = 1'b1;
                    if (!drop_q) begin
                        addr_hold_d = pc;
                    end
                end
            end
        end else begin
            case (state_q)
                FS_REQ: begin
                    if (fire) begin
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else begin
                            instr_d    = imem.imem_rdata;
                            instr_pc_d = pc;
                            state_d    = FS_HOLD;
                        end
                    end
                end
                FS_HOLD: begin
                    if (instr_ready) begin
                        pc_inc  = 1'b1;
                        state_d = FS_REQ;
                    end
                end
                default: state_d = FS_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FS_REQ;
            started_q   <= 1'b0;
            drop_q      <= 1'b0;
            addr_hold_q <= '0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            started_q   <= started_d;
            drop_q      <= drop_d;
            addr_hold_q <= addr_hold_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            misalign_q  <= misalign_d;
        end
    end

    // While a dropped request is still in flight, pc already holds the
    // redirect target; the bus must keep showing the original address.
    assign imem.imem_req  = imem_req_w;
    assign imem.imem_addr = drop_q ? addr_hold_q : pc;

    assign instr_valid  = (state_q == FS_HOLD);
    assign instr        = instr_q;
    assign opcode       = opcode_of(instr_q);
    assign instr_pc     = instr_pc_q;
    assign misalign_err = misalign_q;
    assign dbg_state    = state_q;

endmodule
